dmem_arbiter: RTL and testbench

Shares the single-port data memory between two requesters: the CPU MEM stage (port 0) and a debug/loader port (port 1) used by benches and boot code to preload or inspect memory while the pipeline runs. The arbiter grants one word access at a time through a fixed-latency handshake with round-robin fairness. It stalls the CPU while its access is pending. A saturating counter of CPU wait cycles feeds the stall statistics printed by the bench.

---
 rtl/dmem_arb_pkg.sv | 7 +
 rtl/dmem_arb_rr.sv | 15 +
 rtl/dmem_arbiter.sv | 106 ++++++++++
 tb/tb_dmem_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state encoding, port ids and counter width for the data-memory arbiter
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;
  localparam int WAIT_CNT_W = 16;
endpackage

// File: rtl/dmem_arb_rr.sv
// dmem_arb_rr: two-way round-robin pick between CPU and debug requests
module dmem_arb_rr
  import dmem_arb_pkg::*;
(
  input  logic i_req_cpu,
  input  logic i_req_dbg,
  input  logic i_last_grant,
  output logic o_grant,
  output logic o_valid
);
  always_comb begin
    o_valid = i_req_cpu | i_req_dbg;
    o_grant = (i_req_cpu & i_req_dbg) ? ~i_last_grant : (i_req_dbg ? PORT_DBG : PORT_CPU);
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between the CPU MEM stage and a debug port
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [ADDR_W-1:0]     cpu_addr_i,
  input  logic [DATA_W-1:0]     cpu_wdata_i,
  output logic [DATA_W-1:0]     cpu_rdata_o,
  output logic                  cpu_ack_o,
  output logic                  cpu_stall_o,
  input  logic                  dbg_req_i,
  input  logic                  dbg_we_i,
  input  logic [ADDR_W-1:0]     dbg_addr_i,
  input  logic [DATA_W-1:0]     dbg_wdata_i,
  output logic [DATA_W-1:0]     dbg_rdata_o,
  output logic                  dbg_ack_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  output logic                  grant_o,
  output logic                  busy_o,
  output logic                  align_err_o,
  output logic [WAIT_CNT_W-1:0] cpu_wait_cnt_o
);
  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);
  arb_state_t r_state, w_next;
  logic r_port, r_we, r_last_grant, r_align_err;
  logic [ADDR_W-1:2] r_addr;
  logic [DATA_W-1:0] r_wdata, r_cpu_rdata, r_dbg_rdata;
  logic [2:0] r_cnt;
  logic [WAIT_CNT_W-1:0] r_wait;
  logic w_grant, w_valid, w_issue, w_last, w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  dmem_arb_rr u_rr (
    .i_req_cpu   (cpu_req_i),
    .i_req_dbg   (dbg_req_i),
    .i_last_grant(r_last_grant),
    .o_grant     (w_grant),
    .o_valid     (w_valid)
  );
  always_comb begin
    w_issue = (r_state == IDLE) & w_valid;
    w_last  = (r_state == BUSY) & (r_cnt == '0);
    w_next  = w_issue ? BUSY : w_last ? DONE : (r_state == BUSY) ? BUSY : IDLE;
    w_we    = w_grant ? dbg_we_i : cpu_we_i;
    w_addr  = w_grant ? dbg_addr_i : cpu_addr_i;
    w_wdata = w_grant ? dbg_wdata_i : cpu_wdata_i;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else r_state <= w_next;
  end
  // last_grant resets to the debug port so the CPU wins the first tie
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_port       <= PORT_CPU;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_last_grant <= PORT_DBG;
      r_align_err  <= 1'b0;
      r_cpu_rdata  <= '0;
      r_dbg_rdata  <= '0;
      r_wait       <= '0;
    end else begin
      if (w_issue) begin
        r_port  <= w_grant;
        r_we    <= w_we;
        r_addr  <= w_addr[ADDR_W-1:2];
        r_wdata <= w_wdata;
        r_cnt   <= LAT_M1;
        if (w_addr[1:0] != 2'b00) r_align_err <= 1'b1;
      end else if (r_state == BUSY) r_cnt <= r_cnt - 1'b1;
      if (w_last) begin
        r_last_grant <= r_port;
        if (!r_we && r_port == PORT_CPU) r_cpu_rdata <= mem_rdata_i;
        if (!r_we && r_port == PORT_DBG) r_dbg_rdata <= mem_rdata_i;
      end
      if (cpu_stall_o && r_wait != '1) r_wait <= r_wait + 1'b1;
    end
  end
  assign mem_en_o       = r_state == BUSY;
  assign mem_we_o       = (r_state == BUSY) & r_we;
  assign mem_addr_o     = {r_addr, 2'b00};
  assign mem_wdata_o    = r_wdata;
  assign cpu_ack_o      = (r_state == DONE) & (r_port == PORT_CPU);
  assign dbg_ack_o      = (r_state == DONE) & (r_port == PORT_DBG);
  assign cpu_stall_o    = cpu_req_i & ~cpu_ack_o;
  assign cpu_rdata_o    = r_cpu_rdata;
  assign dbg_rdata_o    = r_dbg_rdata;
  assign grant_o        = r_port;
  assign busy_o         = r_state != IDLE;
  assign align_err_o    = r_align_err;
  assign cpu_wait_cnt_o = r_wait;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: random and directed traffic checked against a transaction-level arbiter model
module tb_dmem_arbiter;
  localparam int LAT = 2;
  typedef struct {
    logic        port;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          g;
  } acc_t;
  logic clk = 0, rst = 1;
  logic cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0;
  logic [4:0] cpu_addr = 0, dbg_addr = 0, mem_addr;
  logic [31:0] cpu_wdata = 0, dbg_wdata = 0, cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic cpu_ack, cpu_stall, dbg_ack, mem_en, mem_we, grant, busy, align_err;
  logic [15:0] wait_cnt;
  logic [31:0] mem [8];
  logic [31:0] shadow [8];
  int total = 0, bad = 0;
  int pc = 0, free_at = 0;
  logic m_last = 1, m_align = 0, cur_v = 0;
  logic [15:0] m_wait = 0;
  logic [31:0] m_rd [2];
  acc_t cur, e, exp_q [$];
  logic en_x, bz_x, ak_x;

  dmem_arbiter #(.ADDR_W(5), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata), .cpu_ack_o(cpu_ack), .cpu_stall_o(cpu_stall),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_rdata_o(dbg_rdata), .dbg_ack_o(dbg_ack),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .grant_o(grant), .busy_o(busy), .align_err_o(align_err),
    .cpu_wait_cnt_o(wait_cnt)
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[4:2]];

  initial begin
    for (int i = 0; i < 8; i++) begin
      mem[i] = (i == 0) ? 32'd5 : $urandom;
      shadow[i] = mem[i];
    end
    m_rd[0] = 0;
    m_rd[1] = 0;
    forever begin
      @(posedge clk);
      if (mem_en && mem_we) mem[mem_addr[4:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one access at a time, arbitration by the round-robin rule,
  // each access occupying LAT+2 cycles from the IDLE cycle that grants it.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      pc = 0; free_at = 0; m_last = 1; m_align = 0; m_wait = 0; cur_v = 0;
      m_rd[0] = 0; m_rd[1] = 0;
      exp_q.delete();
    end else begin
      if (cpu_req && !(cur_v && cur.port == 0 && pc == cur.g + LAT) && m_wait != 16'hFFFF) m_wait++;
      if (pc >= free_at && (cpu_req || dbg_req)) begin
        e.port  = (cpu_req && dbg_req) ? !m_last : dbg_req;
        e.we    = e.port ? dbg_we : cpu_we;
        e.addr  = e.port ? dbg_addr : cpu_addr;
        e.wdata = e.port ? dbg_wdata : cpu_wdata;
        e.rdata = e.we ? 32'd0 : shadow[e.addr[4:2]];
        e.g     = pc + 1;
        if (e.we) shadow[e.addr[4:2]] = e.wdata;
        if (e.addr[1:0] != 0) m_align = 1;
        m_last  = e.port;
        free_at = e.g + LAT + 1;
        cur     = e;
        cur_v   = 1;
        exp_q.push_back(e);
      end
      pc++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      en_x = cur_v && pc >= cur.g && pc < cur.g + LAT;
      bz_x = cur_v && pc >= cur.g && pc <= cur.g + LAT;
      ak_x = cur_v && pc == cur.g + LAT;
      chk("mem_en", mem_en, en_x);
      chk("busy", busy, bz_x);
      chk("stall", cpu_stall, cpu_req && !(ak_x && cur.port == 0));
      chk("align_err", align_err, m_align);
      chk("wait_cnt", wait_cnt, m_wait);
      chk("acks", {dbg_ack, cpu_ack}, ak_x ? (cur.port ? 2'b10 : 2'b01) : 2'b00);
      if (bz_x) chk("grant", grant, cur.port);
      if (en_x) begin
        chk("mem_addr", mem_addr, {cur.addr[4:2], 2'b00});
        chk("mem_we", mem_we, cur.we);
        chk("mem_wdata", mem_wdata, cur.wdata);
      end
      if (cpu_ack || dbg_ack) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL ack_unexpected: got ack with empty scoreboard at t=%0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("ack_port", dbg_ack, e.port);
          if (!e.we) m_rd[e.port] = e.rdata;
        end
      end
      chk("cpu_rdata", cpu_rdata, m_rd[0]);
      chk("dbg_rdata", dbg_rdata, m_rd[1]);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1;
    cpu_req = 0;
    dbg_req = 0;
    tick(2);
    rst = 0;
  endtask

  task automatic cpu_tx(input logic we, input logic [4:0] a, input logic [31:0] d);
    int n = 0;
    cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1;
    do begin @(negedge clk); n++; end while (!cpu_ack && n < 100);
    if (!cpu_ack) begin
      total++; bad++;
      $display("FAIL cpu_timeout: got no ack expected ack within 100 cycles");
    end
    #1 cpu_req = 0;
  endtask

  task automatic dbg_tx(input logic we, input logic [4:0] a, input logic [31:0] d);
    int n = 0;
    dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_req = 1;
    do begin @(negedge clk); n++; end while (!dbg_ack && n < 100);
    if (!dbg_ack) begin
      total++; bad++;
      $display("FAIL dbg_timeout: got no ack expected ack within 100 cycles");
    end
    #1 dbg_req = 0;
  endtask

  initial begin
    tick(3);
    rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_acks", {cpu_ack, dbg_ack}, 0);
    cpu_tx(0, 5'h00, 0);
    chk("first_read", cpu_rdata, 32'd5);
    chk("first_wait", wait_cnt, 16'd3);
    dbg_tx(1, 5'h08, 32'hDEADBEEF);
    cpu_tx(0, 5'h08, 0);
    chk("dbg_write_seen", cpu_rdata, 32'hDEADBEEF);
    do_reset();
    fork
      repeat (3) cpu_tx(0, 5'h04, 0);
      repeat (3) dbg_tx(0, 5'h0C, 0);
    join
    cpu_tx(0, 5'h06, 0);
    chk("align_set", align_err, 1);
    cpu_tx(1, 5'h10, 32'h1234_5678);
    dbg_tx(0, 5'h10, 0);
    chk("align_sticky", align_err, 1);
    chk("aligned_rw", dbg_rdata, 32'h1234_5678);
    do_reset();
    chk("align_clr", align_err, 0);
    dbg_we = 0; dbg_addr = 5'h14; dbg_req = 1;
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("abort_mem_en", mem_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ack", dbg_ack, 0);
    dbg_req = 0;
    tick(1);
    rst = 0;
    fork
      cpu_tx(0, 5'h00, 0);
      dbg_tx(0, 5'h04, 0);
    join
    fork
      repeat (25) begin tick($urandom_range(0, 3)); cpu_tx(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom); end
      repeat (25) begin tick($urandom_range(0, 3)); dbg_tx(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom); end
    join
    do_reset();
    cpu_we = 0; cpu_addr = 0; cpu_req = 1;
    dbg_we = 0; dbg_addr = 5'h04; dbg_req = 1;
    repeat (76000) @(negedge clk);
    chk("wait_sat", wait_cnt, 16'hFFFF);
    #1 cpu_req = 0;
    dbg_req = 0;
    tick(10);
    chk("drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
